rs_issue_scheduler: RTL and testbench
=====================================

Name: rs_issue_scheduler

Overview:
- Per-entry lifecycle controller and issue select for one reservation station (RS).
- Tracks each RS slot through FREE → WAITING → READY → ISSUED.
- Each cycle, picks one READY entry round-robin and presents it to the execute unit with a valid/ready handshake.
- Returns the slot to FREE when Execute drives free_en/free_index on completion.
- Sits between Dispatch/Wakeup (alloc, wake) and Execute (issue, free).

Parameters:
- RS_ENTRIES, 8, number of RS slots; power of two, ≥2.
- IDX_W, $clog2(RS_ENTRIES), slot index width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  pipeline flush; all slots freed
- alloc_en  in  1  Dispatch writes a slot
- alloc_index  in  IDX_W  slot being allocated
- alloc_rdy  in  1  operands already available at allocation
- wake_en  in  1  Wakeup marks a slot's operands ready
- wake_index  in  IDX_W  slot being woken
- issue_valid  out  1  a slot is presented for execution
- issue_index  out  IDX_W  presented slot
- issue_ready  in  1  Execute accepts the presented slot
- free_en  in  1  Execute completed a slot (from Execute side of the Wakeup/Execute interface)
- free_index  in  IDX_W  slot to free
- occupancy  out  IDX_W+1  number of non-FREE slots
- full  out  1  occupancy == RS_ENTRIES
- err_sticky  out  1  illegal alloc/free seen since reset or flush

Behaviour:
- Reset (async, rst=1):
  - All slots FREE; rr pointer = 0.
  - issue_valid=0, issue_index=0, occupancy=0, full=0, err_sticky=0.
- Per-slot state register, 2 bits. Same-cycle updates are evaluated against start-of-cycle state:
  - alloc_en on a FREE slot: slot → READY if alloc_rdy, else WAITING.
  - alloc_en on a non-FREE slot: ignored; err_sticky ← 1.
  - wake_en on a WAITING slot: slot → READY. On any other state: ignored, no error.
  - Handshake accept (issue_valid & issue_ready): presented slot READY → ISSUED.
  - free_en on an ISSUED slot: slot → FREE. On any other state: ignored; err_sticky ← 1.
  - alloc and free to the same index in one cycle: free applies (slot was ISSUED); alloc is illegal and sets err_sticky.
  - alloc and wake to the same index in one cycle: wake ignored; slot takes alloc_rdy.
- Issue outputs are registered; a valid slot is held stable until accepted:
  - If issue_valid=1 and issue_ready=0: issue_valid and issue_index hold. Newly READY slots do not preempt.
  - Otherwise (idle, or accept this cycle): next-cycle issue_index = first READY slot searching upward from rr pointer, with wrap at RS_ENTRIES-1 → 0. The slot accepted this cycle and slots reaching READY only this cycle are excluded.
  - issue_valid = a READY slot was found.
  - On accept: rr pointer ← accepted index + 1, mod RS_ENTRIES.
- Latency and throughput:
  - A slot that becomes READY at edge N can appear on issue_valid at edge N+1, at the earliest.
  - Back-to-back accepts sustain one issue per cycle.
- occupancy and full are registered and reflect post-update state: +1 per legal alloc, -1 per legal free, both in one cycle → net 0.
- flush (highest priority, synchronous):
  - All slots FREE; issue_valid ← 0; occupancy ← 0; err_sticky ← 0; rr pointer ← 0.
  - Same-cycle alloc, wake, free and accept are discarded.
- Async reset asserted mid-handshake drops issue_valid immediately; no slot survives.

Optional Feature:
- Macro: RS_SCHED_PERF_EN.
- Defined:
  - Adds output stall_cycles (32 bits) and output issue_count (32 bits), both reset/flush to 0.
  - stall_cycles increments each cycle with issue_valid=1 & issue_ready=0.
  - issue_count increments on each accept.
  - Both saturate at all-ones.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- CORE_PKG holds RS_ENTRIES and typedef rs_slot_state_e {RS_FREE, RS_WAITING, RS_READY, RS_ISSUED}. IDX_W is derived locally.
- One sub-module, rr_picker: combinational find-first-set over a RS_ENTRIES request vector from a start pointer, with wrap. Outputs found and index.
- Per-slot state update and handshake hold logic stay in rs_issue_scheduler.

Test Plan (RS_ENTRIES=8):
- Reset: rst pulse mid-run → issue_valid=0, occupancy=0, full=0, err_sticky=0 asynchronously.
- Single slot: alloc idx3 with alloc_rdy=1 at cycle 0 → issue_valid=1, issue_index=3 at cycle 1. Accept at cycle 1. free idx3 at cycle 4 → occupancy returns to 0 at cycle 5.
- Round-robin: slots 1,5,6 READY, pointer 0, issue_ready held high → issue_index 1,5,6 on consecutive cycles, then issue_valid=0. rr pointer=7.
- Backpressure: slot 5 presented, issue_ready=0 for 4 cycles, slot 2 woken meanwhile → issue_index stays 5. With RS_SCHED_PERF_EN, stall_cycles=4. After accept, slot 2 is presented the next cycle.
- Illegal ops:
  - alloc idx2 while idx2 WAITING → state unchanged, err_sticky=1.
  - free idx4 while idx4 READY → ignored, err_sticky stays 1.
- Fill and flush: 8 allocs → full=1, occupancy=8. Flush while issue_valid=1 → next cycle issue_valid=0, occupancy=0, full=0, err_sticky=0.

Source files
------------

// File: rtl/rs_issue_scheduler_pkg.sv
// Shared types and defaults for the reservation-station issue scheduler.
package rs_issue_scheduler_pkg;

    localparam int RS_ENTRIES = 8;

    typedef enum logic [1:0] {
        RS_FREE    = 2'd0,
        RS_WAITING = 2'd1,
        RS_READY   = 2'd2,
        RS_ISSUED  = 2'd3
    } rs_slot_state_e;

endpackage

// File: rtl/rs_issue_scheduler_rr_picker.sv
// Find-first-set over a request vector, searching upward from a start
// pointer with wrap-around.
module rs_issue_scheduler_rr_picker #(
    parameter int N = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        found = 1'b0;
        index = '0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = start + IDX_W'(k);
            if (!found && req[pos]) begin
                found = 1'b1;
                index = pos;
            end
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// RS slot lifecycle tracker with registered round-robin issue select.
// Define RS_SCHED_PERF_EN to add stall_cycles/issue_count counters.
module rs_issue_scheduler #(
    parameter int RS_ENTRIES = rs_issue_scheduler_pkg::RS_ENTRIES,
    localparam int IDX_W = $clog2(RS_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc_en,
    input  logic [IDX_W-1:0] alloc_index,
    input  logic             alloc_rdy,
    input  logic             wake_en,
    input  logic [IDX_W-1:0] wake_index,
    output logic             issue_valid,
    output logic [IDX_W-1:0] issue_index,
    input  logic             issue_ready,
    input  logic             free_en,
    input  logic [IDX_W-1:0] free_index,
    output logic [IDX_W:0]   occupancy,
    output logic             full,
    output logic             err_sticky
`ifdef RS_SCHED_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      issue_count
`endif
);

    import rs_issue_scheduler_pkg::*;

    rs_slot_state_e   state_q [RS_ENTRIES];
    rs_slot_state_e   state_d [RS_ENTRIES];
    logic             issue_valid_q, issue_valid_d;
    logic [IDX_W-1:0] issue_index_q, issue_index_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W:0]   occ_q, occ_d;
    logic             full_q, full_d;
    logic             err_q, err_d;

    logic                  accept;
    logic [RS_ENTRIES-1:0] req;
    logic [IDX_W-1:0]      start;
    logic                  found;
    logic [IDX_W-1:0]      pick;

    assign accept = issue_valid_q & issue_ready;

    // All per-slot decisions look at start-of-cycle state only.
    always_comb begin
        err_d = err_q;
        occ_d = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            state_d[i] = state_q[i];
            if (accept && issue_index_q == IDX_W'(i)
                && state_q[i] == RS_READY) begin
                state_d[i] = RS_ISSUED;
            end
            if (wake_en && wake_index == IDX_W'(i)
                && !(alloc_en && alloc_index == IDX_W'(i))
                && state_q[i] == RS_WAITING) begin
                state_d[i] = RS_READY;
            end
            if (alloc_en && alloc_index == IDX_W'(i)) begin
                if (state_q[i] == RS_FREE) begin
                    state_d[i] = alloc_rdy ? RS_READY : RS_WAITING;
                end else begin
                    err_d = 1'b1;
                end
            end
            if (free_en && free_index == IDX_W'(i)) begin
                if (state_q[i] == RS_ISSUED) begin
                    state_d[i] = RS_FREE;
                end else begin
                    err_d = 1'b1;
                end
            end
            if (state_d[i] != RS_FREE) begin
                occ_d = occ_d + 1'b1;
            end
        end
        if (flush) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                state_d[i] = RS_FREE;
            end
            err_d = 1'b0;
            occ_d = '0;
        end
        full_d = (occ_d == (IDX_W+1)'(RS_ENTRIES));
    end

    // Candidates exclude the slot leaving READY via this cycle's accept.
    always_comb begin
        for (int i = 0; i < RS_ENTRIES; i++) begin
            req[i] = (state_q[i] == RS_READY)
                   && !(accept && issue_index_q == IDX_W'(i));
        end
        start = accept ? issue_index_q + 1'b1 : rr_q;
    end

    rs_issue_scheduler_rr_picker #(
        .N(RS_ENTRIES)
    ) u_picker (
        .req  (req),
        .start(start),
        .found(found),
        .index(pick)
    );

    always_comb begin
        rr_d          = accept ? start : rr_q;
        issue_valid_d = issue_valid_q;
        issue_index_d = issue_index_q;
        if (!(issue_valid_q && !issue_ready)) begin
            issue_valid_d = found;
            issue_index_d = pick;
        end
        if (flush) begin
            rr_d          = '0;
            issue_valid_d = 1'b0;
            issue_index_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                state_q[i] <= RS_FREE;
            end
            issue_valid_q <= 1'b0;
            issue_index_q <= '0;
            rr_q          <= '0;
            occ_q         <= '0;
            full_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            issue_valid_q <= issue_valid_d;
            issue_index_q <= issue_index_d;
            rr_q          <= rr_d;
            occ_q         <= occ_d;
            full_q        <= full_d;
            err_q         <= err_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_index = issue_index_q;
    assign occupancy   = occ_q;
    assign full        = full_q;
    assign err_sticky  = err_q;

`ifdef RS_SCHED_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        stall_d = stall_q;
        cnt_d   = cnt_q;
        if (flush) begin
            stall_d = '0;
            cnt_d   = '0;
        end else begin
            if (issue_valid_q && !issue_ready && stall_q != '1) begin
                stall_d = stall_q + 32'd1;
            end
            if (accept && cnt_q != '1) begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            cnt_q   <= '0;
        end else begin
            stall_q <= stall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_cycles = stall_q;
    assign issue_count  = cnt_q;
`endif

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Scenario tasks plus randomized run against a slot-level reference model.
module tb_rs_issue_scheduler;

    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          alloc_en;
    logic [IW-1:0] alloc_index;
    logic          alloc_rdy;
    logic          wake_en;
    logic [IW-1:0] wake_index;
    logic          issue_valid;
    logic [IW-1:0] issue_index;
    logic          issue_ready;
    logic          free_en;
    logic [IW-1:0] free_index;
    logic [IW:0]   occupancy;
    logic          full;
    logic          err_sticky;
`ifdef RS_SCHED_PERF_EN
    logic [31:0]   stall_cycles;
    logic [31:0]   issue_count;
`endif

    rs_issue_scheduler #(.RS_ENTRIES(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .alloc_en   (alloc_en),
        .alloc_index(alloc_index),
        .alloc_rdy  (alloc_rdy),
        .wake_en    (wake_en),
        .wake_index (wake_index),
        .issue_valid(issue_valid),
        .issue_index(issue_index),
        .issue_ready(issue_ready),
        .free_en    (free_en),
        .free_index (free_index),
        .occupancy  (occupancy),
        .full       (full),
        .err_sticky (err_sticky)
`ifdef RS_SCHED_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .issue_count (issue_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: 0 free, 1 waiting, 2 ready, 3 issued.
    int          ms [N];
    int          mrr;
    bit          mv;
    int          midx;
    int          mocc;
    bit          merr;
    int unsigned mstall;
    int unsigned mcnt;

    function automatic void model_reset();
        foreach (ms[i]) ms[i] = 0;
        mrr = 0; mv = 1'b0; midx = 0; mocc = 0; merr = 1'b0;
        mstall = 0; mcnt = 0;
    endfunction

    function automatic void model_step();
        int ns [N];
        bit acc;
        int st;
        int nidx;
        bit fnd;
        int a, w, f, j;
        if (flush) begin
            model_reset();
            return;
        end
        a = int'(alloc_index); w = int'(wake_index); f = int'(free_index);
        acc = mv && issue_ready;
        ns = ms;
        if (acc) ns[midx] = 3;
        if (wake_en && ms[w] == 1 && !(alloc_en && a == w)) ns[w] = 2;
        if (alloc_en) begin
            if (ms[a] == 0) ns[a] = alloc_rdy ? 2 : 1;
            else merr = 1'b1;
        end
        if (free_en) begin
            if (ms[f] == 3) ns[f] = 0;
            else merr = 1'b1;
        end
        if (mv && !issue_ready && mstall != 32'hFFFF_FFFF) mstall++;
        if (acc && mcnt != 32'hFFFF_FFFF) mcnt++;
        if (!(mv && !issue_ready)) begin
            st = acc ? (midx + 1) % N : mrr;
            fnd = 1'b0; nidx = 0;
            for (int k = 0; k < N; k++) begin
                j = (st + k) % N;
                if (!fnd && ms[j] == 2 && !(acc && j == midx)) begin
                    fnd = 1'b1; nidx = j;
                end
            end
            if (acc) mrr = (midx + 1) % N;
            mv = fnd;
            if (fnd) midx = nidx;
        end
        ms = ns;
        mocc = 0;
        foreach (ms[i]) if (ms[i] != 0) mocc++;
    endfunction

    function automatic int find_slot(int want);
        int s;
        s = $urandom_range(N - 1);
        for (int k = 0; k < N; k++) begin
            if (ms[(s + k) % N] == want) return (s + k) % N;
        end
        return -1;
    endfunction

    task automatic clear_inputs();
        flush = 1'b0; alloc_en = 1'b0; alloc_index = '0; alloc_rdy = 1'b0;
        wake_en = 1'b0; wake_index = '0; issue_ready = 1'b0;
        free_en = 1'b0; free_index = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_alloc(int idx, bit rdy);
        alloc_en = 1'b1; alloc_index = IW'(idx); alloc_rdy = rdy;
        tick();
        alloc_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", issue_valid); else n_pass++;
        n_checks++; if (occupancy !== 4'd0) $display("FAIL rst_occ got %0d want 0", occupancy); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL rst_full got %b want 0", full); else n_pass++;
        n_checks++; if (err_sticky !== 1'b0) $display("FAIL rst_err got %b want 0", err_sticky); else n_pass++;
        do_alloc(0, 1'b1);
        do_alloc(1, 1'b1);
        do_alloc(0, 1'b1);
        n_checks++; if (issue_valid !== 1'b1 || issue_index !== 3'd0) $display("FAIL pre_rst_issue got %b/%0d want 1/0", issue_valid, issue_index); else n_pass++;
        n_checks++; if (occupancy !== 4'd2 || err_sticky !== 1'b1) $display("FAIL pre_rst_occ_err got %0d/%b want 2/1", occupancy, err_sticky); else n_pass++;
        issue_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL async_rst_valid got %b want 0", issue_valid); else n_pass++;
        n_checks++; if (occupancy !== 4'd0) $display("FAIL async_rst_occ got %0d want 0", occupancy); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL async_rst_full got %b want 0", full); else n_pass++;
        n_checks++; if (err_sticky !== 1'b0) $display("FAIL async_rst_err got %b want 0", err_sticky); else n_pass++;
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        do_alloc(3, 1'b1);
        n_checks++; if (issue_valid !== 1'b0 || occupancy !== 4'd1) $display("FAIL single_alloc got %b/%0d want 0/1", issue_valid, occupancy); else n_pass++;
        issue_ready = 1'b1;
        tick();
        n_checks++; if (issue_valid !== 1'b1 || issue_index !== 3'd3) $display("FAIL single_issue got %b/%0d want 1/3", issue_valid, issue_index); else n_pass++;
        tick();
        n_checks++; if (issue_valid !== 1'b0 || occupancy !== 4'd1) $display("FAIL single_accept got %b/%0d want 0/1", issue_valid, occupancy); else n_pass++;
        issue_ready = 1'b0;
        tick();
        tick();
        free_en = 1'b1; free_index = 3'd3;
        tick();
        free_en = 1'b0;
        n_checks++; if (occupancy !== 4'd0 || err_sticky !== 1'b0) $display("FAIL single_free got %0d/%b want 0/0", occupancy, err_sticky); else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        do_alloc(1, 1'b1);
        do_alloc(5, 1'b1);
        do_alloc(6, 1'b1);
        n_checks++; if (issue_valid !== 1'b1 || issue_index !== 3'd1) $display("FAIL rr_first got %b/%0d want 1/1", issue_valid, issue_index); else n_pass++;
        issue_ready = 1'b1;
        tick();
        n_checks++; if (issue_valid !== 1'b1 || issue_index !== 3'd5) $display("FAIL rr_second got %b/%0d want 1/5", issue_valid, issue_index); else n_pass++;
        tick();
        n_checks++; if (issue_valid !== 1'b1 || issue_index !== 3'd6) $display("FAIL rr_third got %b/%0d want 1/6", issue_valid, issue_index); else n_pass++;
        tick();
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL rr_drain got %b want 0", issue_valid); else n_pass++;
        do_alloc(0, 1'b0);
        wake_en = 1'b1; wake_index = 3'd0;
        do_alloc(7, 1'b1);
        wake_en = 1'b0;
        tick();
        n_checks++; if (issue_valid !== 1'b1 || issue_index !== 3'd7) $display("FAIL rr_ptr7 got %b/%0d want 1/7", issue_valid, issue_index); else n_pass++;
        tick();
        n_checks++; if (issue_valid !== 1'b1 || issue_index !== 3'd0) $display("FAIL rr_wrap got %b/%0d want 1/0", issue_valid, issue_index); else n_pass++;
        issue_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        do_alloc(2, 1'b0);
        do_alloc(5, 1'b1);
        tick();
        n_checks++; if (issue_valid !== 1'b1 || issue_index !== 3'd5) $display("FAIL bp_present got %b/%0d want 1/5", issue_valid, issue_index); else n_pass++;
        for (int c = 0; c < 4; c++) begin
            wake_en = (c == 0); wake_index = 3'd2;
            tick();
            n_checks++; if (issue_valid !== 1'b1 || issue_index !== 3'd5) $display("FAIL bp_hold%0d got %b/%0d want 1/5", c, issue_valid, issue_index); else n_pass++;
        end
        wake_en = 1'b0;
`ifdef RS_SCHED_PERF_EN
        n_checks++; if (stall_cycles !== 32'd4) $display("FAIL bp_stall got %0d want 4", stall_cycles); else n_pass++;
`endif
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        n_checks++; if (issue_valid !== 1'b1 || issue_index !== 3'd2) $display("FAIL bp_next got %b/%0d want 1/2", issue_valid, issue_index); else n_pass++;
`ifdef RS_SCHED_PERF_EN
        n_checks++; if (issue_count !== 32'd1) $display("FAIL bp_count got %0d want 1", issue_count); else n_pass++;
`endif
    endtask

    task automatic test_illegal();
        do_reset();
        do_alloc(2, 1'b0);
        do_alloc(2, 1'b1);
        n_checks++; if (err_sticky !== 1'b1 || occupancy !== 4'd1) $display("FAIL ill_alloc got %b/%0d want 1/1", err_sticky, occupancy); else n_pass++;
        tick();
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL ill_alloc_state got %b want 0", issue_valid); else n_pass++;
        do_alloc(4, 1'b1);
        tick();
        free_en = 1'b1; free_index = 3'd4;
        tick();
        free_en = 1'b0;
        n_checks++; if (err_sticky !== 1'b1 || occupancy !== 4'd2) $display("FAIL ill_free got %b/%0d want 1/2", err_sticky, occupancy); else n_pass++;
        n_checks++; if (issue_valid !== 1'b1 || issue_index !== 3'd4) $display("FAIL ill_free_keep got %b/%0d want 1/4", issue_valid, issue_index); else n_pass++;
    endtask

    task automatic test_fill_flush();
        do_reset();
        for (int i = 0; i < N; i++) do_alloc(i, 1'b1);
        n_checks++; if (occupancy !== 4'd8 || full !== 1'b1) $display("FAIL fill got %0d/%b want 8/1", occupancy, full); else n_pass++;
        n_checks++; if (issue_valid !== 1'b1 || issue_index !== 3'd0) $display("FAIL fill_issue got %b/%0d want 1/0", issue_valid, issue_index); else n_pass++;
        do_alloc(3, 1'b1);
        n_checks++; if (err_sticky !== 1'b1 || occupancy !== 4'd8) $display("FAIL fill_ill got %b/%0d want 1/8", err_sticky, occupancy); else n_pass++;
        flush = 1'b1; issue_ready = 1'b1; alloc_en = 1'b1; alloc_index = 3'd0;
        tick();
        flush = 1'b0; issue_ready = 1'b0; alloc_en = 1'b0;
        n_checks++; if (issue_valid !== 1'b0 || occupancy !== 4'd0) $display("FAIL flush got %b/%0d want 0/0", issue_valid, occupancy); else n_pass++;
        n_checks++; if (full !== 1'b0 || err_sticky !== 1'b0) $display("FAIL flush_flags got %b/%b want 0/0", full, err_sticky); else n_pass++;
`ifdef RS_SCHED_PERF_EN
        n_checks++; if (stall_cycles !== 32'd0 || issue_count !== 32'd0) $display("FAIL flush_perf got %0d/%0d want 0/0", stall_cycles, issue_count); else n_pass++;
`endif
    endtask

    task automatic test_random();
        int a, w, f;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            alloc_en = ($urandom_range(2) != 0);
            a = find_slot(0);
            if (a < 0 || $urandom_range(9) == 0) a = $urandom_range(N - 1);
            alloc_index = IW'(a);
            alloc_rdy = 1'($urandom_range(1));
            wake_en = ($urandom_range(1) != 0);
            w = find_slot(1);
            if (w < 0 || $urandom_range(7) == 0) w = $urandom_range(N - 1);
            wake_index = IW'(w);
            free_en = ($urandom_range(4) < 2);
            f = find_slot(3);
            if (f < 0 || $urandom_range(9) == 0) f = $urandom_range(N - 1);
            free_index = IW'(f);
            issue_ready = ($urandom_range(3) != 0);
            flush = ($urandom_range(63) == 0);
            tick();
            n_checks++; if (issue_valid !== mv) $display("FAIL rnd_valid c%0d got %b want %b", c, issue_valid, mv); else n_pass++;
            if (mv) begin
                n_checks++; if (issue_index !== IW'(midx)) $display("FAIL rnd_index c%0d got %0d want %0d", c, issue_index, midx); else n_pass++;
            end
            n_checks++; if (occupancy !== (IW+1)'(mocc)) $display("FAIL rnd_occ c%0d got %0d want %0d", c, occupancy, mocc); else n_pass++;
            n_checks++; if (full !== (mocc == N)) $display("FAIL rnd_full c%0d got %b want %b", c, full, mocc == N); else n_pass++;
            n_checks++; if (err_sticky !== merr) $display("FAIL rnd_err c%0d got %b want %b", c, err_sticky, merr); else n_pass++;
`ifdef RS_SCHED_PERF_EN
            n_checks++; if (stall_cycles !== mstall) $display("FAIL rnd_stall c%0d got %0d want %0d", c, stall_cycles, mstall); else n_pass++;
            n_checks++; if (issue_count !== mcnt) $display("FAIL rnd_count c%0d got %0d want %0d", c, issue_count, mcnt); else n_pass++;
`endif
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_illegal();
        test_fill_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
